execute_muldiv: RTL and testbench

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

---
 rtl/execute_muldiv.sv | 221 ++++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
//------------------------------------------------------------------------------
// Module   : execute_muldiv
// Brief    : Iterative multiply/divide unit with architectural HI/LO registers.
//            Both operations use 32 single-bit steps and then a sign-fix cycle.
//            MTHI/MTLO write HI/LO directly while the unit is idle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module execute_muldiv #(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         StartE,
  input  logic [2:0]   OpE,
  input  logic [W-1:0] SrcAE,
  input  logic [W-1:0] SrcBE,
  input  logic         CancelE,
  output logic [W-1:0] Hi,
  output logic [W-1:0] Lo,
  output logic         Busy,
  output logic         Done
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]     state;
  logic [1:0]     next_state;
  logic [CW-1:0]  count;
  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  logic [2*W-1:0] acc;
  logic [W-1:0]   opb;        // multiplicand (MUL) or divisor (DIV) magnitude
  logic [W-1:0]   raw_a;      // unmodified SrcAE, committed to Hi on divide by zero
  logic           neg_main;   // negate product / quotient
  logic           neg_rem;    // negate remainder (dividend was negative)
  logic           div_zero;
  logic           is_div;

  // Control strobes decoded from the FSM
  logic go;
  logic accept_mul;
  logic accept_div;
  logic write_hi;
  logic write_lo;
  logic step_mul;
  logic step_div;
  logic commit;

  // Operand conditioning
  logic           signed_op;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;

  // Datapath step results
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ok;
  logic [W-1:0]   rem_next;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod_fixed;
  logic [W-1:0]   res_hi;
  logic [W-1:0]   res_lo;

  // Signed ops (MULT, DIV) have OpE[0] clear; work on magnitudes for those
  always_comb begin
    signed_op = ~OpE[0];
    a_neg     = signed_op & SrcAE[W-1];
    b_neg     = signed_op & SrcBE[W-1];
    a_mag     = a_neg ? (~SrcAE + 1'b1) : SrcAE;
    b_mag     = b_neg ? (~SrcBE + 1'b1) : SrcBE;
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; cancel always returns to IDLE
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (StartE && !CancelE) begin
          if (OpE == OP_MULT || OpE == OP_MULTU) begin
            next_state = S_MUL;
          end else if (OpE == OP_DIV || OpE == OP_DIVU) begin
            next_state = S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (CancelE) begin
          next_state = S_IDLE;
        end else if (count == LAST_STEP) begin
          next_state = S_FIX;
        end
      end
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // FSM output decode: per-cycle datapath strobes
  always_comb begin
    go         = (state == S_IDLE) && StartE && !CancelE;
    accept_mul = go && (OpE == OP_MULT || OpE == OP_MULTU);
    accept_div = go && (OpE == OP_DIV  || OpE == OP_DIVU);
    write_hi   = go && (OpE == OP_MTHI);
    write_lo   = go && (OpE == OP_MTLO);
    step_mul   = (state == S_MUL) && !CancelE;
    step_div   = (state == S_DIV) && !CancelE;
    commit     = (state == S_FIX) && !CancelE;
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc[W-1:1]};
    div_shift = acc[2*W-1:W-1];
    div_diff  = div_shift - {1'b0, opb};
    div_ok    = ~div_diff[W];
    rem_next  = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
    div_next  = {rem_next, acc[W-2:0], div_ok};
  end

  // Sign correction and special cases applied in FIX
  always_comb begin
    prod_fixed = neg_main ? (~acc + 1'b1) : acc;
    res_hi     = prod_fixed[2*W-1:W];
    res_lo     = prod_fixed[W-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = raw_a;
        res_lo = {W{1'b1}};
      end else begin
        res_lo = neg_main ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
        res_hi = neg_rem ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
      end
    end
  end

  // Operand latch, iteration counter and accumulator
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count    <= '0;
      acc      <= '0;
      opb      <= '0;
      raw_a    <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
    end else if (accept_mul || accept_div) begin
      count    <= '0;
      acc      <= {{W{1'b0}}, (accept_mul ? b_mag : a_mag)};
      opb      <= accept_mul ? a_mag : b_mag;
      raw_a    <= SrcAE;
      neg_main <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= (SrcBE == '0);
      is_div   <= accept_div;
    end else if (step_mul) begin
      acc   <= mul_next;
      count <= count + CW'(1);
    end else if (step_div) begin
      acc   <= div_next;
      count <= count + CW'(1);
    end
  end

  // Architectural HI/LO: direct moves in IDLE, results on commit
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Hi <= '0;
      Lo <= '0;
    end else if (commit) begin
      Hi <= res_hi;
      Lo <= res_lo;
    end else begin
      if (write_hi) Hi <= SrcAE;
      if (write_lo) Lo <= SrcAE;
    end
  end

  // Registered status: Busy tracks non-IDLE state, Done pulses on commit
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      Busy <= (next_state != S_IDLE);
      Done <= commit;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_execute_muldiv.sv
//------------------------------------------------------------------------------
// Module   : tb_execute_muldiv
// Brief    : Self-checking bench for execute_muldiv with a result scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_execute_muldiv;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        StartE = 1'b0;
  logic [2:0]  OpE = 3'b000;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        CancelE = 1'b0;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;

  execute_muldiv #(.W(32)) dut (
    .Clk(Clk), .Reset(Reset), .StartE(StartE), .OpE(OpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .CancelE(CancelE),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Reference model: {Hi, Lo} for each multiply/divide op
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    case (op)
      3'b000: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      3'b001: return {32'b0, a} * {32'b0, b};
      3'b010: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      3'b011: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Scoreboard: every Done must match the oldest pending expectation
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: Done=1 Hi=%h Lo=%h, required no Done", Hi, Lo);
      end else begin
        mon_exp = sb.pop_front();
        if ({Hi, Lo} !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard: Hi:Lo=%h, required %h", {Hi, Lo}, mon_exp);
        end
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge Clk); #1;
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b;
    @(posedge Clk); #1;
    StartE = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (Busy !== 1'b1) break;
      cyc++;
    end
    if (Busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL busy_timeout: Busy=%b after %0d cycles, required 0", Busy, cyc);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
    sb.push_back(model(op, a, b));
    drive(op, a, b);
    wait_idle(cyc);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({Hi, Lo, Busy, Done} !== 66'h0) begin
      errors++;
      $display("FAIL reset_state: Hi=%h Lo=%h Busy=%b Done=%b, required all 0", Hi, Lo, Busy, Done);
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_multu_max();
    int cyc;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    checks++;
    if (cyc != 33) begin
      errors++;
      $display("FAIL multu_busy_len: busy %0d cycles, required 33", cyc);
    end
    checks++;
    if (Done !== 1'b1 || {Hi, Lo} !== 64'hFFFFFFFE_00000001) begin
      errors++;
      $display("FAIL multu_max: Done=%b Hi:Lo=%h, required 1 fffffffe00000001", Done, {Hi, Lo});
    end
    @(negedge Clk);
    checks++;
    if (Done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: Done=%b one cycle later, required 0", Done);
    end
  endtask

  task automatic test_signed();
    int cyc;
    run_op(3'b000, 32'hFFFFFFF9, 32'd3, cyc);
    checks++;
    if ({Hi, Lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
      errors++;
      $display("FAIL mult_neg: Hi:Lo=%h, required ffffffffffffffeb", {Hi, Lo});
    end
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, cyc);
    checks++;
    if ({Hi, Lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++;
      $display("FAIL div_neg: Hi:Lo=%h, required fffffffffffffffd", {Hi, Lo});
    end
  endtask

  task automatic test_div_special();
    int cyc;
    run_op(3'b011, 32'd100, 32'd0, cyc);
    checks++;
    if (cyc != 33 || {Hi, Lo} !== 64'h00000064_FFFFFFFF) begin
      errors++;
      $display("FAIL divu_by_zero: cycles=%0d Hi:Lo=%h, required 33 00000064ffffffff", cyc, {Hi, Lo});
    end
    run_op(3'b010, 32'hFFFFFFFB, 32'd0, cyc);
    checks++;
    if ({Hi, Lo} !== 64'hFFFFFFFB_FFFFFFFF) begin
      errors++;
      $display("FAIL div_by_zero: Hi:Lo=%h, required fffffffbffffffff", {Hi, Lo});
    end
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, cyc);
    checks++;
    if ({Hi, Lo} !== 64'h00000000_80000000) begin
      errors++;
      $display("FAIL div_overflow: Hi:Lo=%h, required 0000000080000000", {Hi, Lo});
    end
  endtask

  task automatic test_mt_ignore();
    int cyc;
    logic [31:0] lo_before;
    drive(3'b100, 32'h1234, 32'h0);
    @(negedge Clk);
    checks++;
    if (Hi !== 32'h1234 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: Hi=%h Busy=%b, required 00001234 0", Hi, Busy);
    end
    drive(3'b101, 32'hCAFE, 32'h0);
    @(negedge Clk);
    checks++;
    if (Lo !== 32'hCAFE || Hi !== 32'h1234) begin
      errors++;
      $display("FAIL mtlo: Hi=%h Lo=%h, required 00001234 0000cafe", Hi, Lo);
    end
    lo_before = Lo;
    sb.push_back(64'h00000000_00000006);
    drive(3'b001, 32'd2, 32'd3);
    repeat (5) @(negedge Clk);
    drive(3'b101, 32'hDEAD, 32'h0);
    @(negedge Clk);
    checks++;
    if (Hi !== 32'h1234 || Lo !== lo_before || Busy !== 1'b1) begin
      errors++;
      $display("FAIL mtlo_while_busy: Hi=%h Lo=%h Busy=%b, required 00001234 %h 1", Hi, Lo, Busy, lo_before);
    end
    wait_idle(cyc);
    checks++;
    if ({Hi, Lo} !== 64'h00000000_00000006) begin
      errors++;
      $display("FAIL multu_after_mt: Hi:Lo=%h, required 0000000000000006", {Hi, Lo});
    end
  endtask

  task automatic test_noop();
    logic [63:0] prev;
    prev = {Hi, Lo};
    drive(3'b110, 32'h1111, 32'h2222);
    @(negedge Clk);
    drive(3'b111, 32'h3333, 32'h4444);
    @(negedge Clk);
    checks++;
    if ({Hi, Lo} !== prev || Busy !== 1'b0) begin
      errors++;
      $display("FAIL noop: Hi:Lo=%h Busy=%b, required %h 0", {Hi, Lo}, Busy, prev);
    end
  endtask

  task automatic test_cancel();
    logic [63:0] prev;
    prev = {Hi, Lo};
    drive(3'b011, 32'd1000, 32'd7);
    repeat (9) @(negedge Clk);
    @(posedge Clk); #1;
    CancelE = 1'b1;
    @(posedge Clk); #1;
    CancelE = 1'b0;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || {Hi, Lo} !== prev) begin
      errors++;
      $display("FAIL cancel_div: Busy=%b Hi:Lo=%h, required 0 %h", Busy, {Hi, Lo}, prev);
    end
    repeat (40) @(negedge Clk);
    checks++;
    if ({Hi, Lo} !== prev) begin
      errors++;
      $display("FAIL cancel_hold: Hi:Lo=%h, required %h", {Hi, Lo}, prev);
    end
    // Start and cancel in the same IDLE cycle: cancel wins
    @(posedge Clk); #1;
    StartE = 1'b1; CancelE = 1'b1; OpE = 3'b100; SrcAE = 32'hBAD;
    @(posedge Clk); #1;
    OpE = 3'b000; SrcBE = 32'd5;
    @(posedge Clk); #1;
    StartE = 1'b0; CancelE = 1'b0;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || {Hi, Lo} !== prev) begin
      errors++;
      $display("FAIL cancel_start: Busy=%b Hi:Lo=%h, required 0 %h", Busy, {Hi, Lo}, prev);
    end
  endtask

  task automatic test_reset_mid();
    drive(3'b100, 32'h7777, 32'h0);
    drive(3'b001, 32'd5, 32'd7);
    repeat (20) @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if ({Hi, Lo, Busy, Done} !== 66'h0) begin
      errors++;
      $display("FAIL reset_mid: Hi=%h Lo=%h Busy=%b Done=%b, required all 0", Hi, Lo, Busy, Done);
    end
    @(posedge Clk); #1;
    Reset = 1'b1;
    StartE = 1'b1; OpE = 3'b100; SrcAE = 32'h55;
    @(posedge Clk); #1;
    StartE = 1'b0;
    @(negedge Clk);
    checks++;
    if (Hi !== 32'h55 || Lo !== 32'h0) begin
      errors++;
      $display("FAIL first_edge_after_reset: Hi=%h Lo=%h, required 00000055 00000000", Hi, Lo);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      if (i % 3 == 0) a = -a;
      run_op(op, a, b, cyc);
      checks++;
      if (cyc != 33) begin
        errors++;
        $display("FAIL b2b_latency[%0d]: busy %0d cycles, required 33", i, cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_special();
    test_mt_ignore();
    test_noop();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge Clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
